// File: rtl/keypad_entry.sv
// keypad_entry: front-panel hex entry register, current address and memory/register command engine.
// Define KEYPAD_ENTRY_READBACK_EN to read back the addressed byte after load, dec and storeinc.
module keypad_entry #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic [15:0] ADDR_RST    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] b_hex,
    input  logic        b_load,
    input  logic        b_storeinc,
    input  logic        b_dec,
    input  logic        b_toA,
    input  logic        b_toX,
    input  logic        b_toY,
    input  logic        b_toSP,
    input  logic        b_toPC,
    output logic [15:0] entry,
    output logic [15:0] addr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [7:0]  rd_data,
    output logic [2:0]  reg_sel,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    input  logic        reg_ack,
    output logic        busy,
    output logic        err
);

    localparam int unsigned      CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MWR  = 2'd1;
    localparam logic [1:0] ST_RWR  = 2'd2;
    localparam logic [1:0] ST_MRD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      entry_q, entry_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [7:0]       mem_wdata_q, mem_wdata_d;
    logic             mem_we_q, mem_we_d;
    logic             mem_re_q, mem_re_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [2:0]       reg_sel_q, reg_sel_d;
    logic [15:0]      reg_wdata_q, reg_wdata_d;
    logic             reg_we_q, reg_we_d;
    logic             busy_q;
    logic             err_q, err_d;

    logic             digit_go_s;
    logic [3:0]       digit_s;
    logic             reg_go_s;
    logic [2:0]       reg_sel_s;
    logic [15:0]      reg_wdata_s;
    logic             any_strobe_s;
    logic [15:0]      addr_inc_s;
    logic [15:0]      addr_dec_s;

`ifndef KEYPAD_ENTRY_READBACK_EN
    logic             unused_rdata_s;
    assign unused_rdata_s = ^mem_rdata;
`endif

    // Lowest-index digit strobe wins when several keys pulse together.
    always_comb begin
        digit_go_s = |b_hex;
        digit_s    = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (b_hex[i]) begin
                digit_s = 4'(i);
            end else begin
                digit_s = digit_s;
            end
        end
    end

    // Register command decode in priority order toPC > toA > toX > toY > toSP.
    always_comb begin
        reg_go_s    = 1'b1;
        reg_sel_s   = 3'd0;
        reg_wdata_s = {8'h00, entry_q[7:0]};
        if (b_toPC) begin
            reg_sel_s   = 3'd4;
            reg_wdata_s = entry_q;
        end else if (b_toA) begin
            reg_sel_s = 3'd0;
        end else if (b_toX) begin
            reg_sel_s = 3'd1;
        end else if (b_toY) begin
            reg_sel_s = 3'd2;
        end else if (b_toSP) begin
            reg_sel_s = 3'd3;
        end else begin
            reg_go_s    = 1'b0;
            reg_wdata_s = 16'h0000;
        end
    end

    assign any_strobe_s = b_load | b_storeinc | b_dec | reg_go_s | digit_go_s;
    assign addr_inc_s   = addr_q + 16'h0001;
    assign addr_dec_s   = addr_q - 16'h0001;

    // Command engine next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        entry_d     = entry_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_re_d    = mem_re_q;
        rd_data_d   = rd_data_q;
        reg_sel_d   = reg_sel_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = reg_we_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (any_strobe_s) begin
                    err_d = 1'b0;
                end else begin
                    err_d = err_q;
                end
                if (b_load) begin
                    addr_d  = entry_q;
                    entry_d = 16'h0000;
`ifdef KEYPAD_ENTRY_READBACK_EN
                    state_d    = ST_MRD;
                    mem_re_d   = 1'b1;
                    mem_addr_d = entry_q;
`endif
                end else if (b_storeinc) begin
                    state_d     = ST_MWR;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = entry_q[7:0];
                end else if (b_dec) begin
                    addr_d = addr_dec_s;
`ifdef KEYPAD_ENTRY_READBACK_EN
                    state_d    = ST_MRD;
                    mem_re_d   = 1'b1;
                    mem_addr_d = addr_dec_s;
`endif
                end else if (reg_go_s) begin
                    state_d     = ST_RWR;
                    reg_we_d    = 1'b1;
                    reg_sel_d   = reg_sel_s;
                    reg_wdata_d = reg_wdata_s;
                end else if (digit_go_s) begin
                    entry_d = {entry_q[11:0], digit_s};
                end else begin
                    entry_d = entry_q;
                end
            end
            ST_MWR: begin
                if (mem_ack) begin
                    mem_we_d    = 1'b0;
                    mem_wdata_d = 8'h00;
                    addr_d      = addr_inc_s;
                    entry_d     = 16'h0000;
`ifdef KEYPAD_ENTRY_READBACK_EN
                    state_d    = ST_MRD;
                    mem_re_d   = 1'b1;
                    mem_addr_d = addr_inc_s;
`else
                    state_d    = ST_IDLE;
                    mem_addr_d = 16'h0000;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    mem_we_d    = 1'b0;
                    mem_wdata_d = 8'h00;
                    mem_addr_d  = 16'h0000;
                    err_d       = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RWR: begin
                if (reg_ack) begin
                    reg_we_d    = 1'b0;
                    reg_sel_d   = 3'd0;
                    reg_wdata_d = 16'h0000;
                    entry_d     = 16'h0000;
                    state_d     = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    reg_we_d    = 1'b0;
                    reg_sel_d   = 3'd0;
                    reg_wdata_d = 16'h0000;
                    err_d       = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_MRD: begin
`ifdef KEYPAD_ENTRY_READBACK_EN
                if (mem_ack) begin
                    rd_data_d  = mem_rdata;
                    mem_re_d   = 1'b0;
                    mem_addr_d = 16'h0000;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_re_d   = 1'b0;
                    mem_addr_d = 16'h0000;
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
`else
                mem_re_d = 1'b0;
                state_d  = ST_IDLE;
`endif
            end
            default: begin
                mem_we_d = 1'b0;
                mem_re_d = 1'b0;
                reg_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            entry_q     <= 16'h0000;
            addr_q      <= ADDR_RST;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rd_data_q   <= 8'h00;
            reg_sel_q   <= 3'd0;
            reg_wdata_q <= 16'h0000;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            entry_q     <= entry_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            rd_data_q   <= rd_data_d;
            reg_sel_q   <= reg_sel_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= (state_d != ST_IDLE);
            err_q       <= err_d;
        end
    end

    assign entry     = entry_q;
    assign addr      = addr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign rd_data   = rd_data_q;
    assign reg_sel   = reg_sel_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
